// File: rtl/seat_pkg.sv
// Shared types and defaults for the seat allocation arbiter.
package seat_pkg;

   localparam int DEF_NREQ    = 4;
   localparam int DEF_SEATS   = 40;
   localparam int DEF_TIMEOUT = 16;
   localparam int MAX_SEATS   = 8;   // largest booking a single requester may ask for

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_HOLD,
      ST_COMMIT,
      ST_RELEASE,
      ST_FAIL
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the search starts at ptr+1 and wraps, so the last winner
// gets the lowest priority on the next pick.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx
);

   // Scan requesters in rotated order and keep the first one found.
   always_comb begin
      int  cand;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/seat_alloc_arbiter.sv
// Seat booking arbiter: picks one requester at a time, reserves its seats,
// holds them until payment, cancellation or timeout, then commits or returns them.
module seat_alloc_arbiter
   import seat_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int SEATS   = DEF_SEATS,
   parameter int TIMEOUT = DEF_TIMEOUT,
   localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int SW     = $clog2(SEATS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*4-1:0] req_seats,
   input  logic [NREQ-1:0]   pay_ok,
   input  logic [NREQ-1:0]   cancel,
   output logic [NREQ-1:0]   grant,
   output logic              book_done,
   output logic              book_fail,
   output logic [IW-1:0]     book_id,
   output logic [SW-1:0]     seats_free,
   output logic              busy
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   winner_q, winner_d;
   logic [3:0]      n_q, n_d;
   logic [SW-1:0]   seats_q, seats_d;
   logic [TW-1:0]   timer_q, timer_d;

   logic [NREQ-1:0] rr_gnt;
   logic [IW-1:0]   rr_idx;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req (req),
      .ptr (ptr_q),
      .gnt (rr_gnt),
      .idx (rr_idx)
   );

   // State register; reset drops any held reservation without a pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= IW'(NREQ - 1);
         winner_q <= '0;
         n_q      <= '0;
         seats_q  <= SW'(SEATS);
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         winner_q <= winner_d;
         n_q      <= n_d;
         seats_q  <= seats_d;
         timer_q  <= timer_d;
      end
   end

   // Next-state logic and seat accounting.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      winner_d = winner_q;
      n_d      = n_q;
      seats_d  = seats_q;
      timer_d  = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (|rr_gnt) begin
               winner_d = rr_idx;
               n_d      = req_seats[int'(rr_idx)*4 +: 4];
               state_d  = ST_CHECK;
            end
         end
         ST_CHECK: begin
            // Compare as integers so a narrow seat counter cannot truncate n.
            if (n_q == 4'd0 || int'(n_q) > MAX_SEATS || int'(n_q) > int'(seats_q)) begin
               state_d = ST_FAIL;
            end else begin
               seats_d = seats_q - SW'(n_q);
               timer_d = '0;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Payment wins over a same-cycle cancel.
            if (pay_ok[winner_q]) begin
               state_d = ST_COMMIT;
            end else if (cancel[winner_q] || timer_q == TW'(TIMEOUT - 1)) begin
               state_d = ST_RELEASE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_COMMIT: begin
            ptr_d   = winner_q;
            state_d = ST_IDLE;
         end
         ST_RELEASE: begin
            seats_d = seats_q + SW'(n_q);
            ptr_d   = winner_q;
            state_d = ST_IDLE;
         end
         ST_FAIL: begin
            ptr_d   = winner_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decode directly from the registered state.
   always_comb begin
      grant      = '0;
      if (state_q == ST_HOLD) grant[winner_q] = 1'b1;
      book_done  = (state_q == ST_COMMIT);
      book_fail  = (state_q == ST_RELEASE) || (state_q == ST_FAIL);
      book_id    = winner_q;
      seats_free = seats_q;
      busy       = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_seat_alloc_arbiter.sv
// Directed bench for seat_alloc_arbiter: a table of booking transactions with
// hand-computed results, plus reset and mid-hold reset sequences.
module tb_seat_alloc_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] req_seats;
   logic [3:0]  pay_ok;
   logic [3:0]  cancel;
   logic [3:0]  grant;
   logic        book_done;
   logic        book_fail;
   logic [1:0]  book_id;
   logic [5:0]  seats_free;
   logic        busy;

   int checks = 0;
   int errors = 0;

   seat_alloc_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_seats  (req_seats),
      .pay_ok     (pay_ok),
      .cancel     (cancel),
      .grant      (grant),
      .book_done  (book_done),
      .book_fail  (book_fail),
      .book_id    (book_id),
      .seats_free (seats_free),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  r;
      logic [15:0] rs;
      logic [3:0]  pay;
      logic [3:0]  can;
      int          act_at;   // HOLD cycle index at which pay/can are driven, -1 never
      logic [3:0]  gnt;      // expected grant in the first post-CHECK cycle
      bit          done;
      bit          fail;
      int          id;
      int          hold;     // expected number of HOLD cycles
      int          seats;    // expected seats_free once back in IDLE
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input int vi, input vec_t v);
      int  hold;
      int  cyc;
      bit  got;
      @(negedge clk);
      req       = v.r;
      req_seats = v.rs;
      @(negedge clk);                       // CHECK cycle; request withdrawn here
      req = 4'b0000;
      chk($sformatf("v%0d check_grant", vi), int'(grant), 0);
      @(negedge clk);                       // HOLD or FAIL
      chk($sformatf("v%0d grant", vi), int'(grant), int'(v.gnt));
      hold = 0;
      cyc  = 0;
      got  = 1'b0;
      while (!got && cyc < 40) begin
         if (book_done || book_fail) begin
            got = 1'b1;
            chk($sformatf("v%0d done", vi), int'(book_done), int'(v.done));
            chk($sformatf("v%0d fail", vi), int'(book_fail), int'(v.fail));
            chk($sformatf("v%0d id", vi), int'(book_id), v.id);
            chk($sformatf("v%0d pulse_grant", vi), int'(grant), 0);
         end else begin
            if (grant != 4'b0000) begin
               if (hold == v.act_at) begin
                  pay_ok = v.pay;
                  cancel = v.can;
               end
               hold++;
            end
            @(negedge clk);
            pay_ok = 4'b0000;
            cancel = 4'b0000;
            cyc++;
         end
      end
      if (!got) chk($sformatf("v%0d pulse_timeout", vi), 0, 1);
      chk($sformatf("v%0d hold_cycles", vi), hold, v.hold);
      @(negedge clk);
      chk($sformatf("v%0d seats_free", vi), int'(seats_free), v.seats);
      chk($sformatf("v%0d busy", vi), int'(busy), 0);
      $display("txn v%0d req=%b id=%0d done=%0d fail=%0d hold=%0d seats_free=%0d",
               vi, v.r, book_id, v.done, v.fail, hold, seats_free);
   endtask

   initial begin
      //          r        rs        pay      can      at  gnt      d  f  id hold seats
      vecs[0]  = '{4'b0001, 16'h0004, 4'b0001, 4'b0000,  2, 4'b0001, 1, 0, 0,  3, 36};
      vecs[1]  = '{4'b1111, 16'h2222, 4'b1111, 4'b0000,  0, 4'b0010, 1, 0, 1,  1, 34};
      vecs[2]  = '{4'b1111, 16'h2222, 4'b1111, 4'b0000,  0, 4'b0100, 1, 0, 2,  1, 32};
      vecs[3]  = '{4'b1111, 16'h2222, 4'b1111, 4'b0000,  0, 4'b1000, 1, 0, 3,  1, 30};
      vecs[4]  = '{4'b1111, 16'h2222, 4'b1111, 4'b0000,  0, 4'b0001, 1, 0, 0,  1, 28};
      vecs[5]  = '{4'b1111, 16'h2222, 4'b1111, 4'b0000,  0, 4'b0010, 1, 0, 1,  1, 26};
      vecs[6]  = '{4'b0100, 16'h0300, 4'b1011, 4'b1011,  0, 4'b0100, 0, 1, 2, 16, 26};
      vecs[7]  = '{4'b1000, 16'h5000, 4'b0000, 4'b1000,  1, 4'b1000, 0, 1, 3,  2, 26};
      vecs[8]  = '{4'b0001, 16'h0008, 4'b0001, 4'b0001,  0, 4'b0001, 1, 0, 0,  1, 18};
      vecs[9]  = '{4'b0010, 16'h0000, 4'b0000, 4'b0000, -1, 4'b0000, 0, 1, 1,  0, 18};
      vecs[10] = '{4'b0100, 16'h0900, 4'b0000, 4'b0000, -1, 4'b0000, 0, 1, 2,  0, 18};
      vecs[11] = '{4'b1000, 16'h8000, 4'b1000, 4'b0000,  0, 4'b1000, 1, 0, 3,  1, 10};
      vecs[12] = '{4'b0001, 16'h0007, 4'b0001, 4'b0000,  0, 4'b0001, 1, 0, 0,  1,  3};
      vecs[13] = '{4'b0010, 16'h0040, 4'b0000, 4'b0000, -1, 4'b0000, 0, 1, 1,  0,  3};
      vecs[14] = '{4'b0100, 16'h0300, 4'b0100, 4'b0000,  0, 4'b0100, 1, 0, 2,  1,  0};
      vecs[15] = '{4'b1000, 16'h1000, 4'b0000, 4'b0000, -1, 4'b0000, 0, 1, 3,  0,  0};

      rst       = 1'b1;
      req       = '0;
      req_seats = '0;
      pay_ok    = '0;
      cancel    = '0;
      repeat (2) @(negedge clk);
      chk("rst seats_free", int'(seats_free), 40);
      chk("rst grant", int'(grant), 0);
      chk("rst done", int'(book_done), 0);
      chk("rst fail", int'(book_fail), 0);
      chk("rst id", int'(book_id), 0);
      chk("rst busy", int'(busy), 0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

      // Reset while holding 5 seats: reservation vanishes, no pulse.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req       = 4'b0001;
      req_seats = 16'h0005;
      @(negedge clk);
      req = 4'b0000;
      @(negedge clk);
      chk("hold_rst grant_before", int'(grant), 1);
      chk("hold_rst seats_before", int'(seats_free), 35);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("hold_rst seats", int'(seats_free), 40);
      chk("hold_rst grant", int'(grant), 0);
      chk("hold_rst pulses", int'({book_done, book_fail}), 0);
      chk("hold_rst busy", int'(busy), 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("hold_rst quiet%0d", c), int'({book_done, book_fail, busy}), 0);
      end
      $display("txn hold_rst seats_free=%0d", seats_free);

      // Pointer is back at its reset value, so requester 0 wins first again.
      run_vec(16, '{4'b1111, 16'h1111, 4'b1111, 4'b0000, 0, 4'b0001, 1, 0, 0, 1, 39});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop guard in case anything wedges.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
